// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// master: the controller (consumes IR fields and ALU flags, drives enables/selects).
// slave:  the datapath (supplies IR fields and ALU flags, consumes enables/selects).
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             overflow;
    logic             PC_Wr;
    logic             IR_Wr;
    logic             Reg_Wr;
    logic [1:0]       Reg_Dst;
    logic             ALU_Src;
    logic [1:0]       ALU_Op;
    logic             Ext_Op;
    logic             Mem_Wr;
    logic [1:0]       Mem_To_Reg;
    logic [1:0]       NPC_Op;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  op, funct, zero, overflow,
        output PC_Wr, IR_Wr, Reg_Wr, Reg_Dst, ALU_Src, ALU_Op, Ext_Op,
               Mem_Wr, Mem_To_Reg, NPC_Op, instr_done, instr_cnt
    );

    modport slave (
        output op, funct, zero, overflow,
        input  PC_Wr, IR_Wr, Reg_Wr, Reg_Dst, ALU_Src, ALU_Op, Ext_Op,
               Mem_Wr, Mem_To_Reg, NPC_Op, instr_done, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/DCD/EXE/MEM/WB over a shared
// datapath and counts retired instructions.
// Optional build macro ILLEGAL_TRAP_EN: an illegal instruction parks the FSM
// in S_HALT until reset instead of retiring as a 2-cycle no-op.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   bus
);

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {S_IF, S_DCD, S_EXE, S_MEM, S_WB, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IF, S_DCD, S_EXE, S_MEM, S_WB} state_t;
`endif

    state_t           state;
    logic             ov_q;
    logic [CNT_W-1:0] cnt_q;

    logic is_r, is_addu, is_subu, is_slt, is_jr;
    logic is_addi, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic legal;

    logic       pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c, done_c;
    logic [1:0] reg_dst_c, alu_op_c, mtr_c, npc_op_c;
    logic       alu_src_c, ext_op_c;

    // Instruction decode from the IR fields
    always_comb begin
        is_r    = (bus.op == 6'b000000);
        is_addu = is_r && (bus.funct == 6'b100001);
        is_subu = is_r && (bus.funct == 6'b100011);
        is_slt  = is_r && (bus.funct == 6'b101010);
        is_jr   = is_r && (bus.funct == 6'b001000);
        is_addi = (bus.op == 6'b001000);
        is_ori  = (bus.op == 6'b001101);
        is_lui  = (bus.op == 6'b001111);
        is_lw   = (bus.op == 6'b100011);
        is_sw   = (bus.op == 6'b101011);
        is_beq  = (bus.op == 6'b000100);
        is_j    = (bus.op == 6'b000010);
        is_jal  = (bus.op == 6'b000011);
        legal   = is_addu | is_subu | is_slt | is_jr | is_addi | is_ori |
                  is_lui | is_lw | is_sw | is_beq | is_j | is_jal;
    end

    // Per-state control decode; ALU selects stay stable from EXE through WB
    always_comb begin
        pc_wr_c   = 1'b0;
        ir_wr_c   = 1'b0;
        reg_wr_c  = 1'b0;
        mem_wr_c  = 1'b0;
        done_c    = 1'b0;
        reg_dst_c = 2'b00;
        alu_src_c = 1'b0;
        alu_op_c  = 2'b00;
        ext_op_c  = 1'b0;
        mtr_c     = 2'b00;
        npc_op_c  = 2'b00;
        if (state == S_EXE || state == S_MEM || state == S_WB) begin
            alu_src_c = is_addi | is_ori | is_lui | is_lw | is_sw;
            ext_op_c  = is_addi | is_lw | is_sw;
            if (is_subu || is_beq) alu_op_c = 2'b01;
            else if (is_ori)       alu_op_c = 2'b10;
            else if (is_slt)       alu_op_c = 2'b11;
        end
        case (state)
            S_IF: begin
                ir_wr_c = 1'b1;
                pc_wr_c = 1'b1;
            end
            S_DCD: begin
                if (is_j) begin
                    pc_wr_c  = 1'b1;
                    npc_op_c = 2'b10;
                    done_c   = 1'b1;
                end else if (is_jal) begin
                    pc_wr_c   = 1'b1;
                    npc_op_c  = 2'b10;
                    reg_wr_c  = 1'b1;
                    reg_dst_c = 2'b10;
                    mtr_c     = 2'b10;
                    done_c    = 1'b1;
                end else if (is_jr) begin
                    pc_wr_c  = 1'b1;
                    npc_op_c = 2'b11;
                    done_c   = 1'b1;
                end else if (!legal) begin
`ifndef ILLEGAL_TRAP_EN
                    done_c = 1'b1;
`endif
                end
            end
            S_EXE: begin
                if (is_beq) begin
                    pc_wr_c  = bus.zero;
                    npc_op_c = 2'b01;
                    done_c   = 1'b1;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    mem_wr_c = 1'b1;
                    done_c   = 1'b1;
                end
            end
            S_WB: begin
                reg_wr_c = 1'b1;
                done_c   = 1'b1;
                if (is_r)                reg_dst_c = 2'b01;
                else if (is_addi && ov_q) reg_dst_c = 2'b11;
                if (is_lw)       mtr_c = 2'b01;
                else if (is_lui) mtr_c = 2'b11;
            end
            default: ;
        endcase
    end

    // State sequencing, addi overflow capture and retired-instruction count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IF;
            ov_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (done_c && legal) cnt_q <= cnt_q + CNT_W'(1);
            case (state)
                S_IF:  state <= S_DCD;
                S_DCD: begin
                    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                        state <= S_HALT;
`else
                        state <= S_IF;
`endif
                    end else if (is_j || is_jal || is_jr) begin
                        state <= S_IF;
                    end else begin
                        state <= S_EXE;
                    end
                end
                S_EXE: begin
                    ov_q <= is_addi & bus.overflow;
                    if (is_beq)               state <= S_IF;
                    else if (is_lw || is_sw)  state <= S_MEM;
                    else                      state <= S_WB;
                end
                S_MEM: state <= is_sw ? S_IF : S_WB;
                S_WB:  state <= S_IF;
`ifdef ILLEGAL_TRAP_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_IF;
            endcase
        end
    end

    // Enables are held low for as long as reset is asserted
    always_comb begin
        bus.PC_Wr      = pc_wr_c  & ~rst;
        bus.IR_Wr      = ir_wr_c  & ~rst;
        bus.Reg_Wr     = reg_wr_c & ~rst;
        bus.Mem_Wr     = mem_wr_c & ~rst;
        bus.instr_done = done_c   & ~rst;
        bus.Reg_Dst    = reg_dst_c;
        bus.ALU_Src    = alu_src_c;
        bus.ALU_Op     = alu_op_c;
        bus.Ext_Op     = ext_op_c;
        bus.Mem_To_Reg = mtr_c;
        bus.NPC_Op     = npc_op_c;
        bus.instr_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class state by state
// and compares the full control vector against hand-computed values.
module tb_mc_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [31:0] exp_cnt;

    mc_ctrl_if #(.CNT_W(32)) bus ();
    mc_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // {PC_Wr, IR_Wr, Reg_Wr, Mem_Wr, instr_done, Reg_Dst, ALU_Src, ALU_Op, Ext_Op, Mem_To_Reg, NPC_Op}
    logic [14:0] ctl;
    assign ctl = {bus.PC_Wr, bus.IR_Wr, bus.Reg_Wr, bus.Mem_Wr, bus.instr_done,
                  bus.Reg_Dst, bus.ALU_Src, bus.ALU_Op, bus.Ext_Op, bus.Mem_To_Reg, bus.NPC_Op};

    localparam logic [14:0] V_NONE    = 15'b0;
    localparam logic [14:0] V_IF      = {5'b11000, 10'b0};
    localparam logic [14:0] V_ADDU_WB = {5'b00101, 2'b01, 8'b0};
    localparam logic [14:0] V_SUBU_WB = {5'b00101, 2'b01, 1'b0, 2'b01, 1'b0, 4'b0};
    localparam logic [14:0] V_SLT_WB  = {5'b00101, 2'b01, 1'b0, 2'b11, 1'b0, 4'b0};
    localparam logic [14:0] V_ORI_WB  = {5'b00101, 2'b00, 1'b1, 2'b10, 1'b0, 4'b0};
    localparam logic [14:0] V_SEXT    = {5'b00000, 2'b00, 1'b1, 2'b00, 1'b1, 4'b0};
    localparam logic [14:0] V_ADDI_OV = {5'b00101, 2'b11, 1'b1, 2'b00, 1'b1, 4'b0};
    localparam logic [14:0] V_ADDI_WB = {5'b00101, 2'b00, 1'b1, 2'b00, 1'b1, 4'b0};
    localparam logic [14:0] V_LW_WB   = {5'b00101, 2'b00, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00};
    localparam logic [14:0] V_SW_MEM  = {5'b00011, 2'b00, 1'b1, 2'b00, 1'b1, 4'b0};
    localparam logic [14:0] V_BEQ_T   = {5'b10001, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 2'b01};
    localparam logic [14:0] V_BEQ_N   = {5'b00001, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 2'b01};
    localparam logic [14:0] V_JAL     = {5'b10101, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10};
    localparam logic [14:0] V_J       = {5'b10001, 8'b0, 2'b10};
    localparam logic [14:0] V_JR      = {5'b10001, 8'b0, 2'b11};
    localparam logic [14:0] V_ILL     = {5'b00001, 10'b0};

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] o, input logic [5:0] f);
        bus.op    = o;
        bus.funct = f;
    endtask

    task automatic test_reset;
        #2;
        n_chk++; if (ctl !== V_NONE) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, V_NONE); end
        n_chk++; if (bus.instr_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.instr_cnt); end
        repeat (2) @(negedge clk);
        n_chk++; if (ctl !== V_NONE) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", ctl, V_NONE); end
        rst = 1'b0;
        #1;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL reset_if: got %b expected %b", ctl, V_IF); end
    endtask

    task automatic test_addu;
        load(6'b000000, 6'b100001);
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL addu_if: got %b expected %b", ctl, V_IF); end
        step;
        n_chk++; if (ctl !== V_NONE) begin n_fail++; $display("FAIL addu_dcd: got %b expected %b", ctl, V_NONE); end
        step;
        n_chk++; if (ctl !== V_NONE) begin n_fail++; $display("FAIL addu_exe: got %b expected %b", ctl, V_NONE); end
        step;
        n_chk++; if (ctl !== V_ADDU_WB) begin n_fail++; $display("FAIL addu_wb: got %b expected %b", ctl, V_ADDU_WB); end
        step;
        exp_cnt++;
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL addu_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL addu_next_if: got %b expected %b", ctl, V_IF); end
    endtask

    task automatic test_addi_overflow;
        for (int k = 0; k < 2; k++) begin
            load(6'b001000, 6'b000000);
            step;
            step;
            bus.overflow = (k == 0);
            n_chk++; if (ctl !== V_SEXT) begin n_fail++; $display("FAIL addi_exe[%0d]: got %b expected %b", k, ctl, V_SEXT); end
            step;
            bus.overflow = 1'b0;
            if (k == 0) begin
                n_chk++; if (ctl !== V_ADDI_OV) begin n_fail++; $display("FAIL addi_wb_ov: got %b expected %b", ctl, V_ADDI_OV); end
            end else begin
                n_chk++; if (ctl !== V_ADDI_WB) begin n_fail++; $display("FAIL addi_wb_nov: got %b expected %b", ctl, V_ADDI_WB); end
            end
            step;
            exp_cnt++;
        end
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL addi_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_lw;
        load(6'b100011, 6'b000000);
        step;
        step;
        n_chk++; if (ctl !== V_SEXT) begin n_fail++; $display("FAIL lw_exe: got %b expected %b", ctl, V_SEXT); end
        step;
        n_chk++; if (ctl !== V_SEXT) begin n_fail++; $display("FAIL lw_mem: got %b expected %b", ctl, V_SEXT); end
        step;
        n_chk++; if (ctl !== V_LW_WB) begin n_fail++; $display("FAIL lw_wb: got %b expected %b", ctl, V_LW_WB); end
        step;
        exp_cnt++;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL lw_next_if: got %b expected %b", ctl, V_IF); end
    endtask

    task automatic test_sw;
        load(6'b101011, 6'b000000);
        step;
        n_chk++; if (ctl !== V_NONE) begin n_fail++; $display("FAIL sw_dcd: got %b expected %b", ctl, V_NONE); end
        step;
        n_chk++; if (ctl !== V_SEXT) begin n_fail++; $display("FAIL sw_exe: got %b expected %b", ctl, V_SEXT); end
        step;
        n_chk++; if (ctl !== V_SW_MEM) begin n_fail++; $display("FAIL sw_mem: got %b expected %b", ctl, V_SW_MEM); end
        step;
        exp_cnt++;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL sw_next_if: got %b expected %b", ctl, V_IF); end
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL sw_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_beq;
        load(6'b000100, 6'b000000);
        bus.zero = 1'b1;
        step;
        step;
        n_chk++; if (ctl !== V_BEQ_T) begin n_fail++; $display("FAIL beq_taken: got %b expected %b", ctl, V_BEQ_T); end
        step;
        exp_cnt++;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL beq_taken_next: got %b expected %b", ctl, V_IF); end
        bus.zero = 1'b0;
        step;
        step;
        n_chk++; if (ctl !== V_BEQ_N) begin n_fail++; $display("FAIL beq_not_taken: got %b expected %b", ctl, V_BEQ_N); end
        step;
        exp_cnt++;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL beq_nt_next: got %b expected %b", ctl, V_IF); end
    endtask

    task automatic test_jumps;
        load(6'b000011, 6'b000000);
        step;
        n_chk++; if (ctl !== V_JAL) begin n_fail++; $display("FAIL jal_dcd: got %b expected %b", ctl, V_JAL); end
        step;
        exp_cnt++;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL jal_next_if: got %b expected %b", ctl, V_IF); end
        load(6'b000010, 6'b000000);
        step;
        n_chk++; if (ctl !== V_J) begin n_fail++; $display("FAIL j_dcd: got %b expected %b", ctl, V_J); end
        step;
        exp_cnt++;
        load(6'b000000, 6'b001000);
        step;
        n_chk++; if (ctl !== V_JR) begin n_fail++; $display("FAIL jr_dcd: got %b expected %b", ctl, V_JR); end
        step;
        exp_cnt++;
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL jump_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_alu_ops;
        load(6'b000000, 6'b100011);
        repeat (3) step;
        n_chk++; if (ctl !== V_SUBU_WB) begin n_fail++; $display("FAIL subu_wb: got %b expected %b", ctl, V_SUBU_WB); end
        step;
        load(6'b000000, 6'b101010);
        repeat (3) step;
        n_chk++; if (ctl !== V_SLT_WB) begin n_fail++; $display("FAIL slt_wb: got %b expected %b", ctl, V_SLT_WB); end
        step;
        load(6'b001101, 6'b000000);
        repeat (3) step;
        n_chk++; if (ctl !== V_ORI_WB) begin n_fail++; $display("FAIL ori_wb: got %b expected %b", ctl, V_ORI_WB); end
        step;
        load(6'b001111, 6'b000000);
        repeat (3) step;
        n_chk++; if ({bus.Reg_Wr, bus.Reg_Dst, bus.Mem_To_Reg, bus.instr_done} !== 6'b100111) begin
            n_fail++; $display("FAIL lui_wb: got %b expected %b", {bus.Reg_Wr, bus.Reg_Dst, bus.Mem_To_Reg, bus.instr_done}, 6'b100111);
        end
        step;
        exp_cnt += 4;
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL alu_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_illegal;
`ifdef ILLEGAL_TRAP_EN
        load(6'b111111, 6'b000000);
        step;
        n_chk++; if (ctl !== V_NONE) begin n_fail++; $display("FAIL ill_trap_dcd: got %b expected %b", ctl, V_NONE); end
        for (int k = 0; k < 10; k++) begin
            step;
            n_chk++; if (ctl !== V_NONE) begin n_fail++; $display("FAIL ill_halt[%0d]: got %b expected %b", k, ctl, V_NONE); end
        end
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL ill_halt_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL ill_after_rst: got %b expected %b", ctl, V_IF); end
`else
        load(6'b111111, 6'b000000);
        step;
        n_chk++; if (ctl !== V_ILL) begin n_fail++; $display("FAIL ill_op_dcd: got %b expected %b", ctl, V_ILL); end
        step;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL ill_op_next: got %b expected %b", ctl, V_IF); end
        load(6'b000000, 6'b111111);
        step;
        n_chk++; if (ctl !== V_ILL) begin n_fail++; $display("FAIL ill_funct_dcd: got %b expected %b", ctl, V_ILL); end
        step;
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL ill_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
`endif
    endtask

    task automatic test_reset_mid;
        load(6'b000000, 6'b100001);
        repeat (3) step;
        n_chk++; if (ctl !== V_ADDU_WB) begin n_fail++; $display("FAIL mid_wb: got %b expected %b", ctl, V_ADDU_WB); end
        rst = 1'b1;
        #1;
        n_chk++; if (bus.Reg_Wr !== 1'b0) begin n_fail++; $display("FAIL mid_regwr: got %b expected 0", bus.Reg_Wr); end
        step;
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        n_chk++; if (ctl !== V_IF) begin n_fail++; $display("FAIL mid_if: got %b expected %b", ctl, V_IF); end
        n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL mid_cnt: got %0d expected %0d", bus.instr_cnt, exp_cnt); end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        n_chk        = 0;
        n_fail       = 0;
        exp_cnt      = 0;
        bus.op       = 6'b0;
        bus.funct    = 6'b0;
        bus.zero     = 1'b0;
        bus.overflow = 1'b0;
        test_reset;
        test_addu;
        test_addi_overflow;
        test_lw;
        test_sw;
        test_beq;
        test_jumps;
        test_alu_ops;
        test_illegal;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
